// File: rtl/fifo_pkt_serializer.sv
// Frames PKT_WORDS show-ahead FIFO words into SOF-headed byte packets, data LSB-first.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte carrying m_eof.
`timescale 1ns/1ps
module fifo_pkt_serializer #(
    parameter int         WIDTH     = 32,
    parameter int         PKT_WORDS = 4,
    parameter logic [7:0] SOF_BYTE  = 8'hA5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_pop,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic             m_eof
);

    localparam int BYTES = WIDTH / 8;
    // Single-byte words / single-word packets still need a 1-bit counter.
    localparam int BIW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(BYTES - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(PKT_WORDS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
`ifdef PKT_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM  = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BIW-1:0]   byte_idx_q, byte_idx_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    // Stream outputs decode from registered state only; m_ready never reaches them.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_sof   = 1'b0;
        m_eof   = 1'b0;
        case (state_q)
            ST_HDR: begin
                m_valid = 1'b1;
                m_data  = SOF_BYTE;
                m_sof   = 1'b1;
            end
            ST_SHIFT: begin
                m_valid = 1'b1;
                m_data  = shreg_q[7:0];
`ifndef PKT_CHECKSUM_EN
                m_eof   = (byte_idx_q == BYTE_LAST) && (word_cnt_q == WORD_LAST);
`endif
            end
`ifdef PKT_CHECKSUM_EN
            ST_CSUM: begin
                m_valid = 1'b1;
                m_data  = csum_q;
                m_eof   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign fifo_pop = (state_q == ST_LOAD) & ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
`ifdef PKT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (m_ready) begin
                    word_cnt_d = '0;
`ifdef PKT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    shreg_d    = fifo_dout;
                    byte_idx_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (m_ready) begin
                    shreg_d    = shreg_q >> 8;
                    byte_idx_d = byte_idx_q + BIW'(1);
`ifdef PKT_CHECKSUM_EN
                    csum_d     = csum_q ^ shreg_q[7:0];
`endif
                    if (byte_idx_q == BYTE_LAST) begin
                        byte_idx_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d = '0;
`ifdef PKT_CHECKSUM_EN
                            state_d    = ST_CSUM;
`else
                            state_d    = ST_IDLE;
`endif
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                            state_d    = ST_LOAD;
                        end
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            ST_CSUM: begin
                if (m_ready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_pkt_serializer.sv
// Directed bench: 32-bit/2-word serializer for framing, stalls and reset; 8-bit/1-word for the minimal packet.
`timescale 1ns/1ps
module tb_fifo_pkt_serializer;

`ifdef PKT_CHECKSUM_EN
    localparam int PLEN   = 10;
    localparam int PLEN_B = 3;
    localparam int LAST_T = 11;
`else
    localparam int PLEN   = 9;
    localparam int PLEN_B = 2;
    localparam int LAST_T = 10;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=32, PKT_WORDS=2
    logic        fifo_empty_a, fifo_pop_a, m_valid_a, m_sof_a, m_eof_a;
    logic        m_ready_a = 1'b0;
    logic [31:0] fifo_dout_a;
    logic [7:0]  m_data_a;
    // DUT B: WIDTH=8, PKT_WORDS=1
    logic        fifo_empty_b, fifo_pop_b, m_valid_b, m_sof_b, m_eof_b;
    logic        m_ready_b = 1'b0;
    logic [7:0]  fifo_dout_b;
    logic [7:0]  m_data_b;

    fifo_pkt_serializer #(.WIDTH(32), .PKT_WORDS(2), .SOF_BYTE(8'hA5)) u_dut_a (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty_a), .fifo_dout(fifo_dout_a),
        .fifo_pop(fifo_pop_a), .m_data(m_data_a), .m_valid(m_valid_a),
        .m_ready(m_ready_a), .m_sof(m_sof_a), .m_eof(m_eof_a)
    );

    fifo_pkt_serializer #(.WIDTH(8), .PKT_WORDS(1), .SOF_BYTE(8'hA5)) u_dut_b (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty_b), .fifo_dout(fifo_dout_b),
        .fifo_pop(fifo_pop_b), .m_data(m_data_b), .m_valid(m_valid_b),
        .m_ready(m_ready_b), .m_sof(m_sof_b), .m_eof(m_eof_b)
    );

    // Show-ahead FIFO models; not reset by rstn.
    logic [31:0] mem_a [0:31];
    logic [7:0]  mem_b [0:31];
    int wr_a = 0, rd_a = 0, pops_a = 0;
    int wr_b = 0, rd_b = 0, pops_b = 0;
    assign fifo_empty_a = (rd_a == wr_a);
    assign fifo_dout_a  = mem_a[rd_a[4:0]];
    assign fifo_empty_b = (rd_b == wr_b);
    assign fifo_dout_b  = mem_b[rd_b[4:0]];

    always @(posedge clk) begin
        if (fifo_pop_a) begin
            rd_a   <= rd_a + 1;
            pops_a <= pops_a + 1;
        end
        if (fifo_pop_b) begin
            rd_b   <= rd_b + 1;
            pops_b <= pops_b + 1;
        end
    end

    // Protocol watcher: held byte must not change or vanish; pops only when non-empty and not streaming.
    int         viol = 0;
    logic       prev_valid = 1'b0, prev_hs = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        #1;
        if (!rstn) begin
            prev_valid <= 1'b0;
        end else begin
            if ((prev_valid && !prev_hs &&
                 (!m_valid_a || m_data_a != prev_data || m_sof_a != prev_sof || m_eof_a != prev_eof)) ||
                (fifo_pop_a && (fifo_empty_a || m_valid_a)) ||
                (fifo_pop_b && (fifo_empty_b || m_valid_b)))
                viol <= viol + 1;
            prev_valid <= m_valid_a;
            prev_hs    <= m_valid_a && m_ready_a;
            prev_data  <= m_data_a;
            prev_sof   <= m_sof_a;
            prev_eof   <= m_eof_a;
        end
    end

    int n_cmp = 0, n_err = 0;
    logic [7:0] cap_d [0:31];
    logic       cap_s [0:31];
    logic       cap_e [0:31];
    int         cap_t [0:31];
    int         ncap;

    logic [7:0] exp1 [0:9];
    logic [7:0] exp4 [0:19];
    logic [7:0] exp5 [0:9];
    logic [7:0] exp6 [0:2];

    task automatic push_a(input logic [31:0] w);
        mem_a[wr_a[4:0]] = w;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [7:0] w);
        mem_b[wr_b[4:0]] = w;
        wr_b = wr_b + 1;
    endtask

    // Records handshakes from the current negedge onward; stops on count or cycle budget.
    task automatic collect(input int sel, input int n, input int budget);
        int cyc;
        cyc  = 0;
        ncap = 0;
        while (ncap < n && cyc < budget) begin
            if (sel == 0 ? (m_valid_a && m_ready_a) : (m_valid_b && m_ready_b)) begin
                cap_d[ncap] = (sel == 0) ? m_data_a : m_data_b;
                cap_s[ncap] = (sel == 0) ? m_sof_a : m_sof_b;
                cap_e[ncap] = (sel == 0) ? m_eof_a : m_eof_b;
                cap_t[ncap] = cyc;
                ncap++;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", m_valid_a); end
        n_cmp++; if (m_data_a !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", m_data_a); end
        n_cmp++; if ({m_sof_a, m_eof_a} !== 2'b00) begin n_err++; $display("FAIL reset_sof_eof: got %b expected 00", {m_sof_a, m_eof_a}); end
        n_cmp++; if (fifo_pop_a !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %b expected 0", fifo_pop_a); end
        n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL reset_valid_b: got %b expected 0", m_valid_b); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL idle_empty_valid: got %b expected 0", m_valid_a); end
    endtask

    task automatic test_basic;
        int p0;
        m_ready_a = 1'b1;
        p0 = pops_a;
        push_a(32'h04030201);
        push_a(32'h08070605);
        collect(0, PLEN, 60);
        n_cmp++; if (ncap !== PLEN) begin n_err++; $display("FAIL basic_count: got %0d expected %0d", ncap, PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            n_cmp++; if (cap_d[i] !== exp1[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h expected %h", i, cap_d[i], exp1[i]); end
            n_cmp++; if (cap_s[i] !== (i == 0)) begin n_err++; $display("FAIL basic_sof%0d: got %b expected %b", i, cap_s[i], i == 0); end
            n_cmp++; if (cap_e[i] !== (i == PLEN - 1)) begin n_err++; $display("FAIL basic_eof%0d: got %b expected %b", i, cap_e[i], i == PLEN - 1); end
        end
        n_cmp++; if (cap_t[PLEN-1] - cap_t[0] !== LAST_T) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", cap_t[PLEN-1] - cap_t[0], LAST_T); end
        n_cmp++; if (pops_a - p0 !== 2) begin n_err++; $display("FAIL basic_pops: got %0d expected 2", pops_a - p0); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL basic_protocol: got %0d expected 0", viol); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int p0, waited;
        m_ready_a = 1'b1;
        push_a(32'h04030201);
        push_a(32'h08070605);
        waited = 0;
        while (!(m_valid_a && m_data_a == 8'h02) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (waited >= 30) begin n_err++; $display("FAIL bp_reach02: got timeout expected byte 02"); end
        m_ready_a = 1'b0;
        p0 = pops_a;
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b expected 1", m_valid_a); end
            n_cmp++; if (m_data_a !== 8'h02) begin n_err++; $display("FAIL bp_data: got %h expected 02", m_data_a); end
            n_cmp++; if (fifo_pop_a !== 1'b0) begin n_err++; $display("FAIL bp_pop: got %b expected 0", fifo_pop_a); end
        end
        m_ready_a = 1'b1;
        collect(0, PLEN - 2, 40);
        n_cmp++; if (ncap !== PLEN - 2) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", ncap, PLEN - 2); end
        for (int i = 0; i < PLEN - 2; i++) begin
            n_cmp++; if (cap_d[i] !== exp1[i+2]) begin n_err++; $display("FAIL bp_byte%0d: got %h expected %h", i + 2, cap_d[i], exp1[i+2]); end
        end
        n_cmp++; if (cap_e[PLEN-3] !== 1'b1) begin n_err++; $display("FAIL bp_eof: got %b expected 1", cap_e[PLEN-3]); end
        n_cmp++; if (pops_a - p0 !== 1) begin n_err++; $display("FAIL bp_pops: got %0d expected 1", pops_a - p0); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL bp_protocol: got %0d expected 0", viol); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_underflow;
        int p0;
        m_ready_a = 1'b1;
        push_a(32'h04030201);
        collect(0, 5, 40);
        n_cmp++; if (ncap !== 5 || cap_d[4] !== 8'h04) begin n_err++; $display("FAIL uf_first_word: got %0d bytes last %h expected 5 bytes last 04", ncap, cap_d[4]); end
        p0 = pops_a;
        repeat (10) begin
            n_cmp++; if ({m_valid_a, fifo_pop_a} !== 2'b00) begin n_err++; $display("FAIL uf_stall: got valid,pop=%b expected 00", {m_valid_a, fifo_pop_a}); end
            @(negedge clk);
        end
        push_a(32'h08070605);
        #1;
        n_cmp++; if (fifo_pop_a !== 1'b1) begin n_err++; $display("FAIL uf_pop_on_push: got %b expected 1", fifo_pop_a); end
        @(negedge clk);
        collect(0, PLEN - 5, 40);
        n_cmp++; if (ncap !== PLEN - 5) begin n_err++; $display("FAIL uf_count: got %0d expected %0d", ncap, PLEN - 5); end
        for (int i = 0; i < PLEN - 5; i++) begin
            n_cmp++; if (cap_d[i] !== exp1[i+5]) begin n_err++; $display("FAIL uf_byte%0d: got %h expected %h", i + 5, cap_d[i], exp1[i+5]); end
        end
        n_cmp++; if (cap_e[PLEN-6] !== 1'b1) begin n_err++; $display("FAIL uf_eof: got %b expected 1", cap_e[PLEN-6]); end
        n_cmp++; if (pops_a - p0 !== 1) begin n_err++; $display("FAIL uf_pops: got %0d expected 1", pops_a - p0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        m_ready_a = 1'b1;
        push_a(32'hDEADBEEF);
        push_a(32'h12345678);
        push_a(32'h11111111);
        push_a(32'h000000FF);
        collect(0, 2 * PLEN, 80);
        n_cmp++; if (ncap !== 2 * PLEN) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", ncap, 2 * PLEN); end
        for (int i = 0; i < 2 * PLEN; i++) begin
            n_cmp++; if (cap_d[i] !== exp4[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h expected %h", i, cap_d[i], exp4[i]); end
            n_cmp++; if (cap_s[i] !== (i == 0 || i == PLEN)) begin n_err++; $display("FAIL b2b_sof%0d: got %b", i, cap_s[i]); end
            n_cmp++; if (cap_e[i] !== (i == PLEN - 1 || i == 2 * PLEN - 1)) begin n_err++; $display("FAIL b2b_eof%0d: got %b", i, cap_e[i]); end
        end
        n_cmp++; if (cap_t[PLEN] - cap_t[PLEN-1] !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d expected 2", cap_t[PLEN] - cap_t[PLEN-1]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_packet;
        int p0;
        m_ready_a = 1'b1;
        push_a(32'h04030201);
        push_a(32'h08070605);
        collect(0, 3, 40);
        n_cmp++; if (m_valid_a !== 1'b1 || m_data_a !== 8'h03) begin n_err++; $display("FAIL rst_pre: got valid %b data %h expected 1 03", m_valid_a, m_data_a); end
        p0 = pops_a;
        rstn = 1'b0;
        #1;
        n_cmp++; if ({m_valid_a, m_sof_a, m_eof_a, fifo_pop_a} !== 4'b0000) begin n_err++; $display("FAIL rst_async_flags: got %b expected 0000", {m_valid_a, m_sof_a, m_eof_a, fifo_pop_a}); end
        n_cmp++; if (m_data_a !== 8'h00) begin n_err++; $display("FAIL rst_async_data: got %h expected 00", m_data_a); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_a(32'h0C0B0A09);
        collect(0, PLEN, 60);
        n_cmp++; if (ncap !== PLEN) begin n_err++; $display("FAIL rst_count: got %0d expected %0d", ncap, PLEN); end
        for (int i = 0; i < PLEN; i++) begin
            n_cmp++; if (cap_d[i] !== exp5[i]) begin n_err++; $display("FAIL rst_byte%0d: got %h expected %h", i, cap_d[i], exp5[i]); end
        end
        n_cmp++; if (cap_s[0] !== 1'b1) begin n_err++; $display("FAIL rst_sof: got %b expected 1", cap_s[0]); end
        n_cmp++; if (pops_a - p0 !== 2) begin n_err++; $display("FAIL rst_pops: got %0d expected 2", pops_a - p0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_word;
        m_ready_b = 1'b1;
        push_b(8'h5C);
        collect(1, PLEN_B, 30);
        n_cmp++; if (ncap !== PLEN_B) begin n_err++; $display("FAIL sw_count: got %0d expected %0d", ncap, PLEN_B); end
        for (int i = 0; i < PLEN_B; i++) begin
            n_cmp++; if (cap_d[i] !== exp6[i]) begin n_err++; $display("FAIL sw_byte%0d: got %h expected %h", i, cap_d[i], exp6[i]); end
            n_cmp++; if (cap_e[i] !== (i == PLEN_B - 1)) begin n_err++; $display("FAIL sw_eof%0d: got %b", i, cap_e[i]); end
        end
        n_cmp++; if (cap_t[1] - cap_t[0] !== 2) begin n_err++; $display("FAIL sw_bubble: got %0d expected 2", cap_t[1] - cap_t[0]); end
        n_cmp++; if (pops_b !== 1) begin n_err++; $display("FAIL sw_pops: got %0d expected 1", pops_b); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL final_protocol: got %0d expected 0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        exp1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        exp5 = '{8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h08};
        exp6 = '{8'hA5, 8'h5C, 8'h5C};
`ifdef PKT_CHECKSUM_EN
        exp4 = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h2A,
                 8'hA5, 8'h11, 8'h11, 8'h11, 8'h11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
`else
        exp4 = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hA5, 8'h11, 8'h11, 8'h11, 8'h11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_underflow();
        test_back_to_back();
        test_reset_mid_packet();
        test_single_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
